// File: rtl/operand_fetch_stage_if.sv
// Fetch, register-file, write-back and ID/EX signals of the operand-fetch stage.
interface operand_fetch_stage_if;
   logic        if_valid;
   logic [15:0] if_instr;
   logic        if_ready;
   logic [3:0]  rf_src1;
   logic [3:0]  rf_src2;
   logic [15:0] rf_data1;
   logic [15:0] rf_data2;
   logic        wb_en;
   logic [3:0]  wb_reg;
   logic [15:0] wb_data;
   logic        flush;
   logic        ex_valid;
   logic        ex_ready;
   logic [3:0]  ex_opcode;
   logic [3:0]  ex_dst;
   logic        ex_wr;
   logic [15:0] ex_op1;
   logic [15:0] ex_op2;
   logic [7:0]  ex_imm;

   modport master (
      output if_valid, if_instr, rf_data1, rf_data2, wb_en, wb_reg, wb_data, flush, ex_ready,
      input  if_ready, rf_src1, rf_src2, ex_valid, ex_opcode, ex_dst, ex_wr, ex_op1, ex_op2, ex_imm
   );

   modport slave (
      input  if_valid, if_instr, rf_data1, rf_data2, wb_en, wb_reg, wb_data, flush, ex_ready,
      output if_ready, rf_src1, rf_src2, ex_valid, ex_opcode, ex_dst, ex_wr, ex_op1, ex_op2, ex_imm
   );
endinterface

// File: rtl/operand_fetch_stage.sv
// Decode/operand fetch with write-back bypass and pending-write scoreboard; 1-cycle accept-to-ex_valid.
// Stalls fetch on RAW/WAW hazards, flush, or a held ID/EX entry (ex_valid & !ex_ready).
module operand_fetch_stage #(
   parameter int NREGS              = 16,
   parameter bit ZERO_REG_HARDWIRED = 1'b1
) (
   input logic                 clk,
   input logic                 rst,
   operand_fetch_stage_if.slave bus
);

   typedef struct packed {
      logic [3:0] src1;
      logic [3:0] src2;
      logic       use1;
      logic       use2;
      logic       wr;
   } dec_t;

   typedef struct packed {
      logic [3:0]  opcode;
      logic [3:0]  dst;
      logic        wr;
      logic [15:0] op1;
      logic [15:0] op2;
      logic [7:0]  imm;
   } idex_t;

   logic [3:0]       opc;
   logic [3:0]       rd;
   logic [3:0]       rs;
   logic [3:0]       rt;
   logic [7:0]       imm_ext;
   dec_t             dec;
   logic             byp1;
   logic             byp2;
   logic [15:0]      op1;
   logic [15:0]      op2;
   logic             blk1;
   logic             blk2;
   logic             waw;
   logic             hazard;
   logic             accept;
   logic [NREGS-1:0] pending;
   logic [NREGS-1:0] pend_nxt;
   idex_t            ex_q;
   logic             ex_valid_q;

   assign opc = bus.if_instr[15:12];
   assign rd  = bus.if_instr[11:8];
   assign rs  = bus.if_instr[7:4];
   assign rt  = bus.if_instr[3:0];

   always_comb begin
      dec = '0;
      if (!opc[3]) begin
         dec.src1 = rs;
         dec.src2 = rt;
         dec.use1 = 1'b1;
         dec.use2 = 1'b1;
         dec.wr   = 1'b1;
      end else begin
         case (opc)
            4'h8: begin
               dec.src1 = rs;
               dec.use1 = 1'b1;
               dec.wr   = 1'b1;
            end
            4'h9: begin
               dec.src1 = rs;
               dec.src2 = rd;
               dec.use1 = 1'b1;
               dec.use2 = 1'b1;
            end
            4'hA, 4'hB: begin
               dec.src1 = rd;
               dec.use1 = 1'b1;
               dec.wr   = 1'b1;
            end
            4'hE: dec.wr = 1'b1;
            default: begin
               dec.src1 = rs;
               dec.use1 = 1'b1;
            end
         endcase
      end
   end

   // LW/SW carry a 4-bit offset; everything else uses the full imm8 field.
   assign imm_ext = (opc == 4'h8 || opc == 4'h9) ? {4'h0, rt} : bus.if_instr[7:0];

   assign byp1 = bus.wb_en && (bus.wb_reg == dec.src1) && !(ZERO_REG_HARDWIRED && dec.src1 == 4'd0);
   assign byp2 = bus.wb_en && (bus.wb_reg == dec.src2) && !(ZERO_REG_HARDWIRED && dec.src2 == 4'd0);
   assign op1  = byp1 ? bus.wb_data : bus.rf_data1;
   assign op2  = byp2 ? bus.wb_data : bus.rf_data2;

   assign blk1   = dec.use1 && pending[dec.src1] && !byp1;
   assign blk2   = dec.use2 && pending[dec.src2] && !byp2;
   assign waw    = dec.wr && pending[rd] && !(bus.wb_en && bus.wb_reg == rd);
   assign hazard = blk1 || blk2 || waw;

   assign bus.if_ready = !hazard && (!ex_valid_q || bus.ex_ready) && !bus.flush;
   assign accept       = bus.if_valid && bus.if_ready;

   assign bus.rf_src1 = dec.src1;
   assign bus.rf_src2 = dec.src2;

   // Clears are applied before the set so a same-cycle set on the same register wins.
   always_comb begin
      pend_nxt = pending;
      if (bus.wb_en)
         pend_nxt[bus.wb_reg] = 1'b0;
      if (bus.flush && ex_valid_q && ex_q.wr)
         pend_nxt[ex_q.dst] = 1'b0;
      if (accept && dec.wr && !(ZERO_REG_HARDWIRED && rd == 4'd0))
         pend_nxt[rd] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ex_q       <= '0;
         ex_valid_q <= 1'b0;
         pending    <= '0;
      end else begin
         pending <= pend_nxt;
         if (bus.flush) begin
            ex_valid_q <= 1'b0;
         end else if (accept) begin
            ex_valid_q  <= 1'b1;
            ex_q.opcode <= opc;
            ex_q.dst    <= rd;
            ex_q.wr     <= dec.wr;
            ex_q.op1    <= op1;
            ex_q.op2    <= op2;
            ex_q.imm    <= imm_ext;
         end else if (bus.ex_ready) begin
            ex_valid_q <= 1'b0;
         end
      end
   end

   assign bus.ex_valid  = ex_valid_q;
   assign bus.ex_opcode = ex_q.opcode;
   assign bus.ex_dst    = ex_q.dst;
   assign bus.ex_wr     = ex_q.wr;
   assign bus.ex_op1    = ex_q.op1;
   assign bus.ex_op2    = ex_q.op2;
   assign bus.ex_imm    = ex_q.imm;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Bench for operand_fetch_stage: decode/bypass vector table plus hazard, stall, flush and reset sequences.
module tb_operand_fetch_stage;

   typedef struct {
      logic [15:0] instr;
      logic [15:0] d1;
      logic [15:0] d2;
      logic        we;
      logic [3:0]  wreg;
      logic [15:0] wd;
      logic [3:0]  e_src1;
      logic [3:0]  e_src2;
      logic [15:0] e_op1;
      logic [15:0] e_op2;
      logic        e_wr;
      logic [7:0]  e_imm;
   } vec_t;

   typedef struct {
      logic [3:0]  opcode;
      logic [3:0]  dst;
      logic        wr;
      logic [15:0] op1;
      logic [15:0] op2;
      logic [7:0]  imm;
   } exp_t;

   localparam int NV = 11;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   errors = 0;
   int   checks = 0;
   exp_t q[$];
   exp_t mon_e;
   vec_t vt[NV];

   operand_fetch_stage_if bus();

   operand_fetch_stage #(.NREGS(16), .ZERO_REG_HARDWIRED(1'b1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [15:0] ins, input logic [15:0] d1, input logic [15:0] d2,
                        input logic we, input logic [3:0] wr, input logic [15:0] wd,
                        input logic fl, input logic er);
      bus.if_valid = v;
      bus.if_instr = ins;
      bus.rf_data1 = d1;
      bus.rf_data2 = d2;
      bus.wb_en    = we;
      bus.wb_reg   = wr;
      bus.wb_data  = wd;
      bus.flush    = fl;
      bus.ex_ready = er;
   endtask

   task automatic push(input logic [15:0] ins, input logic wr, input logic [15:0] o1,
                       input logic [15:0] o2, input logic [7:0] imm);
      exp_t e;
      e.opcode = ins[15:12];
      e.dst    = ins[11:8];
      e.wr     = wr;
      e.op1    = o1;
      e.op2    = o2;
      e.imm    = imm;
      q.push_back(e);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      q.delete();
      drive(1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 4'h0, 16'h0, 1'b0, 1'b1);
      #2;
      rst = 1'b1;
      tick();
   endtask

   function automatic vec_t mkv(input logic [15:0] instr, input logic [15:0] d1, input logic [15:0] d2,
                                input logic we, input logic [3:0] wreg, input logic [15:0] wd,
                                input logic [3:0] s1, input logic [3:0] s2, input logic [15:0] o1,
                                input logic [15:0] o2, input logic wr, input logic [7:0] imm);
      vec_t v;
      v.instr = instr; v.d1 = d1; v.d2 = d2; v.we = we; v.wreg = wreg; v.wd = wd;
      v.e_src1 = s1; v.e_src2 = s2; v.e_op1 = o1; v.e_op2 = o2; v.e_wr = wr; v.e_imm = imm;
      return v;
   endfunction

   // EX side: consume in order, drop squashed entries.
   always @(negedge clk) begin
      if (rst && bus.ex_valid) begin
         if (bus.flush) begin
            if (q.size() > 0) mon_e = q.pop_front();
         end else if (bus.ex_ready) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output: ex_valid=1 with no expected entry at %0t", $time);
            end else begin
               mon_e = q.pop_front();
               chk("ex_opcode", 32'(bus.ex_opcode), 32'(mon_e.opcode));
               chk("ex_dst",    32'(bus.ex_dst),    32'(mon_e.dst));
               chk("ex_wr",     32'(bus.ex_wr),     32'(mon_e.wr));
               chk("ex_op1",    32'(bus.ex_op1),    32'(mon_e.op1));
               chk("ex_op2",    32'(bus.ex_op2),    32'(mon_e.op2));
               chk("ex_imm",    32'(bus.ex_imm),    32'(mon_e.imm));
            end
         end
      end
   end

   initial begin
      logic [15:0] exp_pend;
      logic [3:0]  vrd;

      vt[0]  = mkv(16'h0312, 16'h0005, 16'h0007, 1'b0, 4'h0, 16'h0000, 4'h1, 4'h2, 16'h0005, 16'h0007, 1'b1, 8'h12);
      vt[1]  = mkv(16'h5729, 16'h1111, 16'h2222, 1'b1, 4'h9, 16'hBEEF, 4'h2, 4'h9, 16'h1111, 16'hBEEF, 1'b1, 8'h29);
      vt[2]  = mkv(16'h854C, 16'h0100, 16'h3333, 1'b1, 4'h4, 16'hAAAA, 4'h4, 4'h0, 16'hAAAA, 16'h3333, 1'b1, 8'h0C);
      vt[3]  = mkv(16'h9613, 16'h0042, 16'h0099, 1'b0, 4'h0, 16'h0000, 4'h1, 4'h6, 16'h0042, 16'h0099, 1'b0, 8'h03);
      vt[4]  = mkv(16'hA25A, 16'h7700, 16'h0001, 1'b0, 4'h0, 16'h0000, 4'h2, 4'h0, 16'h7700, 16'h0001, 1'b1, 8'h5A);
      vt[5]  = mkv(16'hBF80, 16'h2468, 16'h0000, 1'b1, 4'hF, 16'h1357, 4'hF, 4'h0, 16'h1357, 16'h0000, 1'b1, 8'h80);
      vt[6]  = mkv(16'hE1AB, 16'h0001, 16'h0002, 1'b0, 4'h0, 16'h0000, 4'h0, 4'h0, 16'h0001, 16'h0002, 1'b1, 8'hAB);
      vt[7]  = mkv(16'hC735, 16'hCAFE, 16'hF00D, 1'b0, 4'h0, 16'h0000, 4'h3, 4'h0, 16'hCAFE, 16'hF00D, 1'b0, 8'h35);
      vt[8]  = mkv(16'hF0F0, 16'h0FF0, 16'h000A, 1'b0, 4'h0, 16'h0000, 4'hF, 4'h0, 16'h0FF0, 16'h000A, 1'b0, 8'hF0);
      vt[9]  = mkv(16'h0400, 16'h0011, 16'h0022, 1'b1, 4'h0, 16'hFFFF, 4'h0, 4'h0, 16'h0011, 16'h0022, 1'b1, 8'h00);
      vt[10] = mkv(16'hD180, 16'h0001, 16'h0002, 1'b1, 4'h8, 16'h5555, 4'h8, 4'h0, 16'h5555, 16'h0002, 1'b0, 8'h80);

      drive(1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 4'h0, 16'h0, 1'b0, 1'b1);
      #12;
      chk("rst_ex_valid",  32'(bus.ex_valid),  32'h0);
      chk("rst_ex_op1",    32'(bus.ex_op1),    32'h0);
      chk("rst_ex_op2",    32'(bus.ex_op2),    32'h0);
      chk("rst_ex_dst",    32'(bus.ex_dst),    32'h0);
      chk("rst_ex_imm",    32'(bus.ex_imm),    32'h0);
      chk("rst_pending",   32'(dut.pending),   32'h0);
      rst = 1'b1;
      tick();

      for (int i = 0; i < NV; i++) begin
         do_reset();
         drive(1'b1, vt[i].instr, vt[i].d1, vt[i].d2, vt[i].we, vt[i].wreg, vt[i].wd, 1'b0, 1'b1);
         #1;
         chk($sformatf("v%0d_rf_src1", i), 32'(bus.rf_src1), 32'(vt[i].e_src1));
         chk($sformatf("v%0d_rf_src2", i), 32'(bus.rf_src2), 32'(vt[i].e_src2));
         chk($sformatf("v%0d_if_ready", i), 32'(bus.if_ready), 32'h1);
         push(vt[i].instr, vt[i].e_wr, vt[i].e_op1, vt[i].e_op2, vt[i].e_imm);
         tick();
         drive(1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 4'h0, 16'h0, 1'b0, 1'b1);
         vrd = vt[i].instr[11:8];
         exp_pend = (vt[i].e_wr && vrd != 4'h0) ? (16'h1 << vrd) : 16'h0;
         chk($sformatf("v%0d_ex_valid", i), 32'(bus.ex_valid), 32'h1);
         chk($sformatf("v%0d_pending", i), 32'(dut.pending), 32'(exp_pend));
         tick();
      end

      // RAW: SUB r4,r3,r1 waits for write-back of r3, then takes the bypassed value.
      do_reset();
      drive(1'b1, 16'h0312, 16'h0005, 16'h0007, 1'b0, 4'h0, 16'h0, 1'b0, 1'b1);
      push(16'h0312, 1'b1, 16'h0005, 16'h0007, 8'h12);
      tick();
      drive(1'b1, 16'h1431, 16'h9999, 16'h0005, 1'b0, 4'h0, 16'h0, 1'b0, 1'b1);
      #1;
      chk("raw_stall_0", 32'(bus.if_ready), 32'h0);
      tick();
      chk("raw_stall_1", 32'(bus.if_ready), 32'h0);
      drive(1'b1, 16'h1431, 16'h9999, 16'h0005, 1'b1, 4'h3, 16'h1234, 1'b0, 1'b1);
      #1;
      chk("raw_release", 32'(bus.if_ready), 32'h1);
      push(16'h1431, 1'b1, 16'h1234, 16'h0005, 8'h31);
      tick();
      drive(1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 4'h0, 16'h0, 1'b0, 1'b1);
      chk("raw_pending", 32'(dut.pending), 32'h0010);
      tick();

      // Backpressure: entry holds for 3 cycles, then is replaced without a bubble.
      do_reset();
      drive(1'b1, 16'h0312, 16'h000A, 16'h000B, 1'b0, 4'h0, 16'h0, 1'b0, 1'b0);
      push(16'h0312, 1'b1, 16'h000A, 16'h000B, 8'h12);
      tick();
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, 16'h2556, 16'h000C, 16'h000D, 1'b0, 4'h0, 16'h0, 1'b0, 1'b0);
         #1;
         chk($sformatf("hold%0d_if_ready", k), 32'(bus.if_ready), 32'h0);
         chk($sformatf("hold%0d_ex_valid", k), 32'(bus.ex_valid), 32'h1);
         chk($sformatf("hold%0d_ex_op1", k),   32'(bus.ex_op1),   32'h000A);
         chk($sformatf("hold%0d_ex_dst", k),   32'(bus.ex_dst),   32'h3);
         tick();
      end
      drive(1'b1, 16'h2556, 16'h000C, 16'h000D, 1'b0, 4'h0, 16'h0, 1'b0, 1'b1);
      #1;
      chk("hold_release_if_ready", 32'(bus.if_ready), 32'h1);
      push(16'h2556, 1'b1, 16'h000C, 16'h000D, 8'h56);
      tick();
      drive(1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 4'h0, 16'h0, 1'b0, 1'b1);
      chk("no_bubble_ex_valid", 32'(bus.ex_valid), 32'h1);
      chk("no_bubble_ex_dst",   32'(bus.ex_dst),   32'h5);
      tick();

      // WAW on r5, released by write-back of r5 in the same cycle the new writer is accepted.
      do_reset();
      drive(1'b1, 16'h854C, 16'h0100, 16'h0200, 1'b0, 4'h0, 16'h0, 1'b0, 1'b1);
      push(16'h854C, 1'b1, 16'h0100, 16'h0200, 8'h0C);
      tick();
      drive(1'b1, 16'h0512, 16'h0021, 16'h0022, 1'b0, 4'h0, 16'h0, 1'b0, 1'b1);
      #1;
      chk("waw_stall_0", 32'(bus.if_ready), 32'h0);
      tick();
      chk("waw_stall_1", 32'(bus.if_ready), 32'h0);
      drive(1'b1, 16'h0512, 16'h0021, 16'h0022, 1'b1, 4'h5, 16'h7777, 1'b0, 1'b1);
      #1;
      chk("waw_release", 32'(bus.if_ready), 32'h1);
      push(16'h0512, 1'b1, 16'h0021, 16'h0022, 8'h12);
      tick();
      drive(1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 4'h0, 16'h0, 1'b0, 1'b1);
      chk("waw_set_wins", 32'(dut.pending), 32'h0020);
      tick();

      // Flush a pending writer to r6; the instruction presented that cycle is not taken.
      do_reset();
      drive(1'b1, 16'h0612, 16'h0001, 16'h0002, 1'b0, 4'h0, 16'h0, 1'b0, 1'b0);
      push(16'h0612, 1'b1, 16'h0001, 16'h0002, 8'h12);
      tick();
      chk("pre_flush_pending", 32'(dut.pending), 32'h0040);
      drive(1'b1, 16'h0712, 16'h0003, 16'h0004, 1'b0, 4'h0, 16'h0, 1'b1, 1'b0);
      #1;
      chk("flush_if_ready", 32'(bus.if_ready), 32'h0);
      tick();
      drive(1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 4'h0, 16'h0, 1'b0, 1'b1);
      chk("flush_ex_valid", 32'(bus.ex_valid), 32'h0);
      chk("flush_pending",  32'(dut.pending),  32'h0);
      tick();

      // Asynchronous reset in the middle of a cycle.
      do_reset();
      drive(1'b1, 16'h0912, 16'h00AB, 16'h00CD, 1'b0, 4'h0, 16'h0, 1'b0, 1'b0);
      push(16'h0912, 1'b1, 16'h00AB, 16'h00CD, 8'h12);
      tick();
      drive(1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 4'h0, 16'h0, 1'b0, 1'b0);
      chk("pre_arst_ex_valid", 32'(bus.ex_valid), 32'h1);
      #1;
      rst = 1'b0;
      q.delete();
      #1;
      chk("arst_ex_valid", 32'(bus.ex_valid), 32'h0);
      chk("arst_ex_op1",   32'(bus.ex_op1),   32'h0);
      chk("arst_pending",  32'(dut.pending),  32'h0);
      rst = 1'b1;
      tick();
      tick();

      chk("scoreboard_drained", 32'(q.size()), 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
